// File: rtl/uart_frame_rx_if.sv
// Byte-in / frame-out bus of the UART framing stage.
//   rx_drdy_in, rx_data_in : raw received byte strobe and data
//   pix_*                  : payload stream (FWFT FIFO head, valid/ready)
//   cmd_out, len_out       : header fields of the current/last frame
//   cmd_valid_out          : header-complete pulse
//   frame_ok_out/err_out   : end-of-frame pulses, err_code_out reason
//   busy_out               : frame in progress
// master = the UART/consumer side, slave = the framer.
interface uart_frame_rx_if;
  logic        rx_drdy_in;
  logic [7:0]  rx_data_in;
  logic [7:0]  pix_data_out;
  logic        pix_last_out;
  logic        pix_valid_out;
  logic        pix_ready_in;
  logic [7:0]  cmd_out;
  logic [15:0] len_out;
  logic        cmd_valid_out;
  logic        frame_ok_out;
  logic        frame_err_out;
  logic [1:0]  err_code_out;
  logic        busy_out;

  modport master (
    output rx_drdy_in, rx_data_in, pix_ready_in,
    input  pix_data_out, pix_last_out, pix_valid_out, cmd_out, len_out,
           cmd_valid_out, frame_ok_out, frame_err_out, err_code_out, busy_out
  );

  modport slave (
    input  rx_drdy_in, rx_data_in, pix_ready_in,
    output pix_data_out, pix_last_out, pix_valid_out, cmd_out, len_out,
           cmd_valid_out, frame_ok_out, frame_err_out, err_code_out, busy_out
  );
endinterface

// File: rtl/uart_frame_rx.sv
// Host frame parser: SOF, CMD, LEN_H, LEN_L, payload, CHK (XOR).
// Ports:
//   clk_in  : system clock
//   rst_in  : asynchronous active-low reset
//   bus     : uart_frame_rx_if.slave (byte input, payload stream, status)
// Payload bytes go through a small first-word-fall-through FIFO whose
// entries carry {last, data}. A full FIFO drops bytes (still counted and
// checksummed) and marks the frame as overflowed.
module uart_frame_rx #(
  parameter logic [7:0]  SOF_BYTE    = 8'hA5,
  parameter int unsigned FIFO_AW     = 3,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic            clk_in,
  input  logic            rst_in,
  uart_frame_rx_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;
  localparam int unsigned TW    = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_LEN_H, S_LEN_L, S_PAYLOAD, S_CHK
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_OVF  = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;
  localparam logic [1:0] ERR_CHK  = 2'd3;

  state_t         state_q;
  logic [7:0]     cmd_q;
  logic [15:0]    len_q;
  logic [15:0]    rem_q;
  logic [7:0]     chk_q;
  logic           ovf_q;
  logic [TW-1:0]  tmo_q;
  logic           cmd_valid_q;
  logic           ok_q;
  logic           err_q;
  logic [1:0]     err_code_q;

  logic [8:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_q;
  logic [FIFO_AW-1:0] rd_q;
  logic [CW-1:0]      cnt_q;
  logic [CW-1:0]      cnt_d;
  logic               pix_valid_q;

  logic push_req_c;
  logic push_c;
  logic pop_c;
  logic full_c;
  logic drop_c;
  logic [15:0] len_new_c;

  // FIFO handshake; a full FIFO still accepts when the head leaves this cycle
  always_comb begin
    pop_c      = pix_valid_q && bus.pix_ready_in;
    full_c     = (cnt_q == CW'(DEPTH));
    push_req_c = bus.rx_drdy_in && (state_q == S_PAYLOAD);
    push_c     = push_req_c && (!full_c || pop_c);
    drop_c     = push_req_c && !push_c;
    len_new_c  = {len_q[15:8], bus.rx_data_in};
    cnt_d      = cnt_q;
    if (push_c && !pop_c) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!push_c && pop_c) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // FIFO storage and pointers
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      if (push_c) begin
        mem_q[wr_q] <= {(rem_q == 16'd1), bus.rx_data_in};
        wr_q        <= wr_q + FIFO_AW'(1);
      end
      if (pop_c) begin
        rd_q <= rd_q + FIFO_AW'(1);
      end
      cnt_q       <= cnt_d;
      pix_valid_q <= (cnt_d != '0);
    end
  end

  // Frame state machine, header registers, checksum, timeout and status pulses
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      len_q       <= '0;
      rem_q       <= '0;
      chk_q       <= '0;
      ovf_q       <= 1'b0;
      tmo_q       <= '0;
      cmd_valid_q <= 1'b0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      cmd_valid_q <= 1'b0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
      if (bus.rx_drdy_in) begin
        // a byte always wins over a coincident timeout
        tmo_q <= '0;
        unique case (state_q)
          S_IDLE: begin
            if (bus.rx_data_in == SOF_BYTE) begin
              state_q    <= S_CMD;
              err_code_q <= ERR_NONE;
              ovf_q      <= 1'b0;
            end
          end
          S_CMD: begin
            cmd_q   <= bus.rx_data_in;
            chk_q   <= bus.rx_data_in;
            state_q <= S_LEN_H;
          end
          S_LEN_H: begin
            len_q[15:8] <= bus.rx_data_in;
            chk_q       <= chk_q ^ bus.rx_data_in;
            state_q     <= S_LEN_L;
          end
          S_LEN_L: begin
            len_q[7:0]  <= bus.rx_data_in;
            chk_q       <= chk_q ^ bus.rx_data_in;
            rem_q       <= len_new_c;
            cmd_valid_q <= 1'b1;
            state_q     <= (len_new_c == 16'd0) ? S_CHK : S_PAYLOAD;
          end
          S_PAYLOAD: begin
            chk_q <= chk_q ^ bus.rx_data_in;
            if (rem_q != 16'd0) begin
              rem_q <= rem_q - 16'd1;
            end
            if (drop_c) begin
              ovf_q <= 1'b1;
            end
            if (rem_q <= 16'd1) begin
              state_q <= S_CHK;
            end
          end
          S_CHK: begin
            state_q <= S_IDLE;
            if (ovf_q) begin
              err_q      <= 1'b1;
              err_code_q <= ERR_OVF;
            end else if (bus.rx_data_in != chk_q) begin
              err_q      <= 1'b1;
              err_code_q <= ERR_CHK;
            end else begin
              ok_q <= 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end else if (state_q != S_IDLE) begin
        if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          // abandon the frame; queued payload is left for the consumer
          state_q    <= S_IDLE;
          tmo_q      <= '0;
          err_q      <= 1'b1;
          err_code_q <= ERR_TMO;
        end else begin
          tmo_q <= tmo_q + TW'(1);
        end
      end
    end
  end

  assign bus.pix_data_out  = mem_q[rd_q][7:0];
  assign bus.pix_last_out  = mem_q[rd_q][8];
  assign bus.pix_valid_out = pix_valid_q;
  assign bus.cmd_out       = cmd_q;
  assign bus.len_out       = len_q;
  assign bus.cmd_valid_out = cmd_valid_q;
  assign bus.frame_ok_out  = ok_q;
  assign bus.frame_err_out = err_q;
  assign bus.err_code_out  = err_code_q;
  assign bus.busy_out      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx (timeout shortened to 50 cycles).
module tb_uart_frame_rx;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  always #5 clk_in = ~clk_in;

  uart_frame_rx_if bus ();

  uart_frame_rx #(
    .SOF_BYTE    (8'hA5),
    .FIFO_AW     (3),
    .TIMEOUT_CYC (50)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  // pulse counters and payload capture, sampled at the active edge (pre-update values)
  int n_cmdv  = 0;
  int n_ok    = 0;
  int n_err   = 0;
  int n_vcyc  = 0;
  logic [7:0] cap_data [$];
  logic       cap_last [$];

  always @(posedge clk_in) begin
    if (bus.cmd_valid_out) n_cmdv++;
    if (bus.frame_ok_out)  n_ok++;
    if (bus.frame_err_out) n_err++;
    if (bus.pix_valid_out) n_vcyc++;
    if (bus.pix_valid_out && bus.pix_ready_in && rst_in) begin
      cap_data.push_back(bus.pix_data_out);
      cap_last.push_back(bus.pix_last_out);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_in);
    bus.rx_drdy_in = 1'b1;
    bus.rx_data_in = b;
    @(negedge clk_in);
    bus.rx_drdy_in = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_in);
    total++; if (bus.busy_out !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy_out); end
    total++; if (bus.pix_valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.pix_valid_out); end
    total++; if (bus.cmd_out !== 8'h00 || bus.len_out !== 16'h0000) begin bad++; $display("FAIL reset_hdr got=%h/%h exp=00/0000", bus.cmd_out, bus.len_out); end
    total++; if (bus.err_code_out !== 2'd0 || bus.frame_err_out !== 1'b0 || bus.frame_ok_out !== 1'b0 || bus.cmd_valid_out !== 1'b0) begin
      bad++; $display("FAIL reset_status got=%0d%b%b%b exp=0000", bus.err_code_out, bus.frame_err_out, bus.frame_ok_out, bus.cmd_valid_out); end
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic test_good_frame();
    int base;
    bus.pix_ready_in = 1'b1;
    base = cap_data.size();
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h00); send_byte(8'h03);
    total++; if (bus.cmd_valid_out !== 1'b1) begin bad++; $display("FAIL good_cmdv got=%b exp=1", bus.cmd_valid_out); end
    total++; if (bus.cmd_out !== 8'h10 || bus.len_out !== 16'd3) begin bad++; $display("FAIL good_hdr got=%h/%0d exp=10/3", bus.cmd_out, bus.len_out); end
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h13);
    total++; if (bus.frame_ok_out !== 1'b1 || bus.frame_err_out !== 1'b0 || bus.err_code_out !== 2'd0) begin
      bad++; $display("FAIL good_end got=ok%b err%b code%0d exp=ok1 err0 code0", bus.frame_ok_out, bus.frame_err_out, bus.err_code_out); end
    repeat (3) @(negedge clk_in);
    total++;
    if (cap_data.size() - base !== 3) begin
      bad++; $display("FAIL good_count got=%0d exp=3", cap_data.size() - base);
    end else if (cap_data[base] !== 8'h11 || cap_data[base+1] !== 8'h22 || cap_data[base+2] !== 8'h33 ||
                 cap_last[base] !== 1'b0 || cap_last[base+1] !== 1'b0 || cap_last[base+2] !== 1'b1) begin
      bad++; $display("FAIL good_pix got=%h%b %h%b %h%b exp=110 220 331", cap_data[base], cap_last[base],
                      cap_data[base+1], cap_last[base+1], cap_data[base+2], cap_last[base+2]);
    end
  endtask

  task automatic test_zero_len();
    int vbase;
    int cbase;
    vbase = n_vcyc;
    cbase = n_cmdv;
    send_byte(8'hA5); send_byte(8'h20); send_byte(8'h00); send_byte(8'h00);
    total++; if (bus.cmd_valid_out !== 1'b1 || bus.len_out !== 16'd0) begin bad++; $display("FAIL zero_cmdv got=%b/%0d exp=1/0", bus.cmd_valid_out, bus.len_out); end
    send_byte(8'h20);
    total++; if (bus.frame_ok_out !== 1'b1) begin bad++; $display("FAIL zero_ok got=%b exp=1", bus.frame_ok_out); end
    repeat (2) @(negedge clk_in);
    total++; if (n_vcyc - vbase !== 0 || n_cmdv - cbase !== 1) begin bad++; $display("FAIL zero_pix got=vcyc%0d cmdv%0d exp=vcyc0 cmdv1", n_vcyc - vbase, n_cmdv - cbase); end
  endtask

  task automatic test_chk_err();
    int base;
    base = cap_data.size();
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h00); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h14);
    total++; if (bus.frame_err_out !== 1'b1 || bus.frame_ok_out !== 1'b0 || bus.err_code_out !== 2'd3) begin
      bad++; $display("FAIL chk_end got=err%b ok%b code%0d exp=err1 ok0 code3", bus.frame_err_out, bus.frame_ok_out, bus.err_code_out); end
    repeat (3) @(negedge clk_in);
    total++; if (cap_data.size() - base !== 3) begin bad++; $display("FAIL chk_count got=%0d exp=3", cap_data.size() - base); end
  endtask

  task automatic test_overflow();
    int base;
    int badpix;
    bus.pix_ready_in = 1'b0;
    base = cap_data.size();
    send_byte(8'hA5); send_byte(8'h40); send_byte(8'h00); send_byte(8'h0A);
    for (int i = 1; i <= 10; i++) send_byte(8'(i));
    total++; if (bus.pix_valid_out !== 1'b1) begin bad++; $display("FAIL ovf_valid got=%b exp=1", bus.pix_valid_out); end
    send_byte(8'h41);
    total++; if (bus.frame_err_out !== 1'b1 || bus.err_code_out !== 2'd1) begin
      bad++; $display("FAIL ovf_end got=err%b code%0d exp=err1 code1", bus.frame_err_out, bus.err_code_out); end
    bus.pix_ready_in = 1'b1;
    repeat (12) @(negedge clk_in);
    badpix = 0;
    if (cap_data.size() - base == 8) begin
      for (int i = 0; i < 8; i++) begin
        if (cap_data[base+i] !== 8'(i + 1) || cap_last[base+i] !== 1'b0) badpix++;
      end
    end
    total++; if (cap_data.size() - base !== 8 || badpix !== 0) begin
      bad++; $display("FAIL ovf_drain got=count%0d badpix%0d exp=count8 badpix0", cap_data.size() - base, badpix); end
    total++; if (bus.pix_valid_out !== 1'b0 || bus.err_code_out !== 2'd1) begin
      bad++; $display("FAIL ovf_after got=valid%b code%0d exp=valid0 code1", bus.pix_valid_out, bus.err_code_out); end
  endtask

  task automatic test_timeout();
    int early;
    send_byte(8'hA5); send_byte(8'h30);
    early = 0;
    repeat (49) begin
      @(negedge clk_in);
      if (bus.frame_err_out) early++;
    end
    total++; if (early !== 0) begin bad++; $display("FAIL tmo_early got=%0d exp=0", early); end
    @(negedge clk_in);
    total++; if (bus.frame_err_out !== 1'b1 || bus.err_code_out !== 2'd2 || bus.busy_out !== 1'b0) begin
      bad++; $display("FAIL tmo_end got=err%b code%0d busy%b exp=err1 code2 busy0", bus.frame_err_out, bus.err_code_out, bus.busy_out); end
    send_byte(8'hA5);
    total++; if (bus.busy_out !== 1'b1 || bus.err_code_out !== 2'd0) begin
      bad++; $display("FAIL tmo_next got=busy%b code%0d exp=busy1 code0", bus.busy_out, bus.err_code_out); end
    send_byte(8'h30); send_byte(8'h00); send_byte(8'h00); send_byte(8'h30);
    total++; if (bus.frame_ok_out !== 1'b1) begin bad++; $display("FAIL tmo_recover got=%b exp=1", bus.frame_ok_out); end
  endtask

  task automatic test_junk_reset();
    int junk_busy;
    int c0, o0, e0;
    junk_busy = 0;
    c0 = n_cmdv;
    send_byte(8'h00); if (bus.busy_out) junk_busy++;
    send_byte(8'hFF); if (bus.busy_out) junk_busy++;
    send_byte(8'h5A); if (bus.busy_out) junk_busy++;
    total++; if (junk_busy !== 0 || n_cmdv !== c0) begin bad++; $display("FAIL junk got=busy%0d cmdv%0d exp=busy0 cmdv0", junk_busy, n_cmdv - c0); end
    bus.pix_ready_in = 1'b0;
    send_byte(8'hA5); send_byte(8'h50); send_byte(8'h00); send_byte(8'h04);
    send_byte(8'h01); send_byte(8'h02);
    total++; if (bus.busy_out !== 1'b1 || bus.pix_valid_out !== 1'b1) begin
      bad++; $display("FAIL rst_pre got=busy%b valid%b exp=busy1 valid1", bus.busy_out, bus.pix_valid_out); end
    c0 = n_cmdv; o0 = n_ok; e0 = n_err;
    @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    total++; if (bus.busy_out !== 1'b0 || bus.pix_valid_out !== 1'b0) begin
      bad++; $display("FAIL rst_mid got=busy%b valid%b exp=busy0 valid0", bus.busy_out, bus.pix_valid_out); end
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    total++; if (n_cmdv !== c0 || n_ok !== o0 || n_err !== e0 || bus.busy_out !== 1'b0) begin
      bad++; $display("FAIL rst_pulses got=cmdv%0d ok%0d err%0d busy%b exp=0 0 0 0", n_cmdv - c0, n_ok - o0, n_err - e0, bus.busy_out); end
  endtask

  task automatic test_back_to_back();
    int o0;
    int base;
    bus.pix_ready_in = 1'b1;
    o0 = n_ok;
    base = cap_data.size();
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h00); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h13);
    send_byte(8'hA5); send_byte(8'h20); send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
    repeat (3) @(negedge clk_in);
    total++; if (n_ok - o0 !== 2 || cap_data.size() - base !== 3 || bus.cmd_out !== 8'h20 || bus.len_out !== 16'd0) begin
      bad++; $display("FAIL b2b got=ok%0d pix%0d cmd%h len%0d exp=ok2 pix3 cmd20 len0", n_ok - o0, cap_data.size() - base, bus.cmd_out, bus.len_out); end
  endtask

  initial begin
    bus.rx_drdy_in   = 1'b0;
    bus.rx_data_in   = 8'h00;
    bus.pix_ready_in = 1'b0;
    test_reset();
    test_good_frame();
    test_zero_len();
    test_chk_err();
    test_overflow();
    test_timeout();
    test_junk_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
